bcd_display_converter: RTL and testbench

Sequential, parametrised binary-to-decimal display driver. Accepts an unsigned WIDTH-bit value on a start strobe and converts it to DIGITS packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. Drives one active-low seven-segment code per digit. It sits between switch/counter logic and the HEX outputs, and supersedes the fixed 4-bit, two-digit combinational display path with an arbitrary-width, multi-digit converter that has overflow indication.

---
 rtl/bcd_display_converter.sv | 167 ++++++++++++++++
 tb/tb_bcd_display_converter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving
// active-low seven-segment codes. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_display_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   step_scratch;
  logic                  step_ovf;
  logic [7*DIGITS-1:0]   hex_conv;
  logic [3:0]            digit;
  logic                  seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every digit before the shift.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // The top digit's MSB is about to be shifted out: the value does not fit.
  assign step_scratch = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
  assign step_ovf     = ovf_q | adj[4*DIGITS-1];

  // Display codes for the result as it will stand after this iteration.
  always_comb begin
    hex_conv = {(7*DIGITS){1'b1}};
    seen_nz  = 1'b0;
    digit    = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = step_scratch[4*k +: 4];
      if (step_ovf) begin
        hex_conv[7*k +: 7] = SEG_DASH;
      end else if (BLANK_EN && !seen_nz && (digit == 4'd0) && (k != 0)) begin
        hex_conv[7*k +: 7] = SEG_BLANK;
      end else begin
        hex_conv[7*k +: 7] = seg7(digit);
      end
      if (digit != 4'd0) seen_nz = 1'b1;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    hex_d     = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = value;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        shift_d   = shift_q << 1;
        scratch_d = step_scratch;
        ovf_d     = step_ovf;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bcd_d   = step_scratch;
          hex_d   = hex_conv;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      hex_q     <= {(7*DIGITS){1'b1}};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      hex_q     <= hex_d;
    end
  end

  assign busy = (state_q == CONVERT);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Scoreboard bench for bcd_display_converter: a 3-digit and a 2-digit instance,
// expected results queued on accept and compared when done pulses.
module tb_bcd_display_converter;

  localparam int W = 8;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  typedef struct packed {
    logic [11:0] bcd;
    logic [20:0] hex;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start3, start2;
  logic [7:0]  value3, value2;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [20:0] hex3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [13:0] hex2;

  exp_t q3[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt3 = 0;
  int   done_cnt2 = 0;

  always #5 clk = ~clk;

  bcd_display_converter #(.WIDTH(W), .DIGITS(3)) dut3 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start3), .value(value3),
    .busy(busy3), .done(done3), .ovf(ovf3), .bcd(bcd3), .HEX(hex3)
  );

  bcd_display_converter #(.WIDTH(W), .DIGITS(2)) dut2 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start2), .value(value2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .HEX(hex2)
  );

  function automatic exp_t model(input int unsigned v, input int nd);
    exp_t        m;
    int unsigned lim;
    int unsigned r;
    int          dg[3];
    bit          seen;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    m     = '0;
    m.ovf = (v >= lim);
    r     = v % lim;
    for (int k = 0; k < 3; k++) dg[k] = 0;
    for (int k = 0; k < nd; k++) begin
      dg[k] = int'(r % 10);
      r = r / 10;
      m.bcd[4*k +: 4] = 4'(dg[k]);
    end
    seen = 1'b0;
    for (int k = nd - 1; k >= 0; k--) begin
      if (m.ovf) m.hex[7*k +: 7] = 7'b0111111;
      else if (BLANK && !seen && dg[k] == 0 && k > 0) m.hex[7*k +: 7] = 7'b1111111;
      else m.hex[7*k +: 7] = SEG[dg[k]];
      if (dg[k] != 0) seen = 1'b1;
    end
    return m;
  endfunction

  // Scoreboard: pop and compare whenever a done pulse is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done3) begin
        done_cnt3++;
        if (q3.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb3_unexpected_done: got done with empty queue, want none");
        end else begin
          e = q3.pop_front();
          n_vec++;
          if (bcd3 !== e.bcd) begin n_err++; $display("FAIL sb3_bcd: got %h want %h", bcd3, e.bcd); end
          n_vec++;
          if (hex3 !== e.hex) begin n_err++; $display("FAIL sb3_hex: got %b want %b", hex3, e.hex); end
          n_vec++;
          if (ovf3 !== e.ovf) begin n_err++; $display("FAIL sb3_ovf: got %b want %b", ovf3, e.ovf); end
        end
      end
      if (done2) begin
        done_cnt2++;
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb2_unexpected_done: got done with empty queue, want none");
        end else begin
          e = q2.pop_front();
          n_vec++;
          if ({4'h0, bcd2} !== e.bcd) begin n_err++; $display("FAIL sb2_bcd: got %h want %h", bcd2, e.bcd); end
          n_vec++;
          if ({7'h0, hex2} !== e.hex) begin n_err++; $display("FAIL sb2_hex: got %b want %b", hex2, e.hex); end
          n_vec++;
          if (ovf2 !== e.ovf) begin n_err++; $display("FAIL sb2_ovf: got %b want %b", ovf2, e.ovf); end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accept one value on the selected instance, then wait (bounded) for done.
  task automatic run_one(input bit sel, input logic [7:0] v, input exp_t e,
                         output int busy_n, output int lat);
    if (sel) begin q2.push_back(e); start2 = 1'b1; value2 = v; end
    else     begin q3.push_back(e); start3 = 1'b1; value3 = v; end
    cyc();
    start2 = 1'b0;
    start3 = 1'b0;
    value2 = 8'($urandom);
    value3 = 8'($urandom);
    busy_n = 0;
    lat    = -1;
    for (int i = 1; i <= 60; i++) begin
      if (sel ? done2 : done3) begin
        lat = i - 1;
        break;
      end
      if (sel ? busy2 : busy3) busy_n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0; value3 = '0; value2 = '0;
    repeat (3) cyc();
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy3); end
    n_vec++; if (done3 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done3); end
    n_vec++; if (ovf3 !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf3); end
    n_vec++; if (bcd3 !== 12'h000) begin n_err++; $display("FAIL rst_bcd: got %h want 000", bcd3); end
    n_vec++; if (hex3 !== {21{1'b1}}) begin n_err++; $display("FAIL rst_hex: got %b want all ones", hex3); end
    n_vec++; if (hex2 !== {14{1'b1}}) begin n_err++; $display("FAIL rst_hex2: got %b want all ones", hex2); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_convert();
    int   vals[10];
    exp_t e;
    int   busy_n, lat;
    vals = '{255, 0, 7, 128, 9, 10, 99, 0, 0, 0};
    for (int i = 7; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      if (i == 0) e = '{bcd: 12'h255, hex: {7'b0100100, 7'b0010010, 7'b0010010}, ovf: 1'b0};
      else        e = model(vals[i], 3);
      run_one(1'b0, 8'(vals[i]), e, busy_n, lat);
      n_vec++; if (lat !== W) begin n_err++; $display("FAIL conv_latency v=%0d: got %0d want %0d", vals[i], lat, W); end
      n_vec++; if (busy_n !== W) begin n_err++; $display("FAIL conv_busy_cycles v=%0d: got %0d want %0d", vals[i], busy_n, W); end
      cyc();
      n_vec++; if (done3 !== 1'b0) begin n_err++; $display("FAIL conv_done_width v=%0d: got %b want 0", vals[i], done3); end
    end
    for (int i = 0; i < 3; i++) begin
      vals[0] = int'($urandom_range(0, 255));
      run_one(1'b1, 8'(vals[0]), model(vals[0], 2), busy_n, lat);
      n_vec++; if (lat !== W) begin n_err++; $display("FAIL conv2_latency v=%0d: got %0d want %0d", vals[0], lat, W); end
      cyc();
    end
  endtask

  task automatic test_overflow();
    int busy_n, lat;
    run_one(1'b1, 8'd99, model(99, 2), busy_n, lat);
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL ovf99_latency: got %0d want %0d", lat, W); end
    cyc();
    run_one(1'b1, 8'd100, model(100, 2), busy_n, lat);
    n_vec++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf100_flag: got %b want 1", ovf2); end
    cyc();
    q2.push_back(model(5, 2));
    start2 = 1'b1; value2 = 8'd5;
    cyc();
    start2 = 1'b0; value2 = 8'd77;
    n_vec++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_accept: got %b want 0", ovf2); end
    n_vec++; if (hex2 !== {2{7'b0111111}}) begin n_err++; $display("FAIL ovf_hex_held: got %b want dashes", hex2); end
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (done2) begin lat = i - 1; break; end
      cyc();
    end
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL ovf5_latency: got %0d want %0d", lat, W); end
    cyc();
  endtask

  task automatic test_start_ignored();
    int dc;
    q3.push_back(model(13, 3));
    start3 = 1'b1; value3 = 8'd13;
    cyc();
    start3 = 1'b0;
    dc = done_cnt3;
    for (int i = 1; i <= 14; i++) begin
      start3 = (i == 3 || i == 5);
      value3 = 8'd42;
      cyc();
    end
    start3 = 1'b0;
    repeat (2) cyc();
    n_vec++; if (done_cnt3 - dc !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt3 - dc); end
    n_vec++; if (bcd3 !== 12'h013) begin n_err++; $display("FAIL ignore_bcd: got %h want 013", bcd3); end
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL ignore_idle: got busy %b want 0", busy3); end
  endtask

  task automatic test_back_to_back();
    int dones, t1, t2, busy_low;
    q3.push_back(model(200, 3));
    q3.push_back(model(201, 3));
    start3 = 1'b1; value3 = 8'd200;
    cyc();
    value3 = 8'd201;
    dones = 0; t1 = -1; t2 = -1; busy_low = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done3) begin
        dones++;
        if (dones == 1) t1 = i;
        else begin t2 = i; start3 = 1'b0; break; end
      end
      if (dones == 1 && !busy3) busy_low++;
      cyc();
    end
    start3 = 1'b0;
    n_vec++; if (dones !== 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", dones); end
    n_vec++; if (t1 !== W + 1) begin n_err++; $display("FAIL b2b_first_done: got %0d want %0d", t1, W + 1); end
    n_vec++; if (t2 - t1 !== W + 1) begin n_err++; $display("FAIL b2b_period: got %0d want %0d", t2 - t1, W + 1); end
    n_vec++; if (busy_low !== 1) begin n_err++; $display("FAIL b2b_busy_gap: got %0d want 1", busy_low); end
    cyc();
    n_vec++; if (bcd3 !== 12'h201) begin n_err++; $display("FAIL b2b_final_bcd: got %h want 201", bcd3); end
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL b2b_no_third: got busy %b want 0", busy3); end
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid();
    int   dc, busy_n, lat;
    exp_t dropped;
    q3.push_back(model(255, 3));
    start3 = 1'b1; value3 = 8'd255;
    cyc();
    start3 = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    dropped = q3.pop_back();
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy3); end
    n_vec++; if (done3 !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done3); end
    n_vec++; if (ovf3 !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", ovf3); end
    n_vec++; if (bcd3 !== 12'h000) begin n_err++; $display("FAIL midrst_bcd: got %h want 000 (dropped %h)", bcd3, dropped.bcd); end
    n_vec++; if (hex3 !== {21{1'b1}}) begin n_err++; $display("FAIL midrst_hex: got %b want all ones", hex3); end
    dc = done_cnt3;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    n_vec++; if (done_cnt3 !== dc) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt3 - dc); end
    run_one(1'b0, 8'd128, model(128, 3), busy_n, lat);
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL midrst_after_latency: got %0d want %0d", lat, W); end
    cyc();
    n_vec++; if (bcd3 !== 12'h128) begin n_err++; $display("FAIL midrst_after_bcd: got %h want 128", bcd3); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    repeat (3) cyc();
    n_vec++; if (q3.size() !== 0) begin n_err++; $display("FAIL sb3_leftover: got %0d want 0", q3.size()); end
    n_vec++; if (q2.size() !== 0) begin n_err++; $display("FAIL sb2_leftover: got %0d want 0", q2.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
